// File: rtl/seq_assign_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_assign_sched_if
//  Description : Configuration, control and result bundle for the
//                sequential/concurrent assignment scheduler.
//                master : drives cfg_*, mode, start, abort; observes out,
//                         busy, done.
//                slave  : the scheduler side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_assign_sched_if #(
   parameter int CH = 3,
   parameter int W  = 1,
   parameter int DW = 4
) ();
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

   logic            cfg_we;
   logic [CHW-1:0]  cfg_ch;
   logic [W-1:0]    cfg_val;
   logic [DW-1:0]   cfg_dly;
   logic            mode;
   logic            start;
   logic            abort;
   logic [CH*W-1:0] out;
   logic            busy;
   logic            done;

   modport master (
      output cfg_we, cfg_ch, cfg_val, cfg_dly, mode, start, abort,
      input  out, busy, done
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_val, cfg_dly, mode, start, abort,
      output out, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/seq_assign_sched.sv
`default_nettype none
// ============================================================================
//  Module      : seq_assign_sched
//  Description : Applies a per-channel value after a per-channel delay.
//                mode 0 : channels update one after another, delays add up.
//                mode 1 : all delays count from the launch edge.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                bus.cfg_*  - value/delay register write (IDLE only)
//                bus.mode   - 0 sequential, 1 concurrent (latched at start)
//                bus.start  - launch request
//                bus.abort  - stop an active run
//                bus.out    - CH*W channel outputs, channel k at [k*W +: W]
//                bus.busy   - run active
//                bus.done   - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_assign_sched #(
   parameter int CH = 3,
   parameter int W  = 1,
   parameter int DW = 4
) (
   input  logic               clk,
   input  logic               rst,
   seq_assign_sched_if.slave  bus
);
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

   localparam logic [CHW-1:0] IDX_LAST = CHW'(CH - 1);
   localparam logic [CHW-1:0] IDX_ONE  = CHW'(1);
   localparam logic [CHW:0]   CH_LIM   = (CHW+1)'(CH);
   localparam logic [DW:0]    CNT_ONE  = (DW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN_SEQ = 2'd1,
      S_RUN_PAR = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t           state_q;
   logic [CH*W-1:0]  out_q;
   logic             busy_q;
   logic             done_q;
   logic [DW:0]      cnt_q;   // one extra bit so a full 2^DW count never wraps
   logic [CHW-1:0]   idx_q;
   logic [W-1:0]     val_q [CH];
   logic [DW-1:0]    dly_q [CH];

   logic [DW-1:0]    max_dly;
   logic [DW-1:0]    cur_dly;

   // Largest programmed delay marks the final edge of a concurrent run.
   always_comb begin
      max_dly = '0;
      for (int k = 0; k < CH; k++) begin
         if (dly_q[k] > max_dly) max_dly = dly_q[k];
      end
   end

   // Delay of the channel currently being serviced in a sequential run.
   always_comb begin
      cur_dly = '0;
      for (int k = 0; k < CH; k++) begin
         if (idx_q == CHW'(k)) cur_dly = dly_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         for (int k = 0; k < CH; k++) begin
            val_q[k] <= '0;
            dly_q[k] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  // A launch takes precedence over a config write in the same cycle.
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= bus.mode ? S_RUN_PAR : S_RUN_SEQ;
               end else if (bus.cfg_we && ({1'b0, bus.cfg_ch} < CH_LIM)) begin
                  for (int k = 0; k < CH; k++) begin
                     if (bus.cfg_ch == CHW'(k)) begin
                        val_q[k] <= bus.cfg_val;
                        dly_q[k] <= bus.cfg_dly;
                     end
                  end
               end
            end

            S_RUN_SEQ: begin
               if (bus.abort) begin
                  // Any update due on this edge is dropped.
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (cnt_q == {1'b0, cur_dly}) begin
                  for (int k = 0; k < CH; k++) begin
                     if (idx_q == CHW'(k)) out_q[k*W +: W] <= val_q[k];
                  end
                  cnt_q <= '0;
                  if (idx_q == IDX_LAST) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     idx_q <= idx_q + IDX_ONE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            S_RUN_PAR: begin
               if (bus.abort) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  for (int k = 0; k < CH; k++) begin
                     if ({1'b0, dly_q[k]} == cnt_q) out_q[k*W +: W] <= val_q[k];
                  end
                  if (cnt_q == {1'b0, max_dly}) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.out  = out_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_assign_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_assign_sched
//  Description : Directed scoreboard bench. Stimulus pushes the expected
//                (edge, out, busy, done) tuples; monitors pop one tuple each
//                time the observed outputs change and compare.
//                u_dut  : CH=3 W=1 DW=4
//                u_dut8 : CH=3 W=1 DW=8 (long-delay case)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_assign_sched;
   typedef struct {
      int         e;
      logic [2:0] o;
      logic       b;
      logic       d;
   } ev_t;

   logic clk;
   logic rst;
   int   edge_n;
   int   checks;
   int   errors;
   ev_t  q0[$];
   ev_t  q1[$];

   seq_assign_sched_if #(.CH(3), .W(1), .DW(4)) m0 ();
   seq_assign_sched_if #(.CH(3), .W(1), .DW(8)) m1 ();

   seq_assign_sched #(.CH(3), .W(1), .DW(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (m0)
   );

   seq_assign_sched #(.CH(3), .W(1), .DW(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (m1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // ---------------- monitors ----------------
   bit         seen0, seen1;
   logic [4:0] prev0, prev1;
   ev_t        ev0, ev1;

   always @(negedge clk) begin
      if (!seen0 || {m0.out, m0.busy, m0.done} != prev0) begin
         seen0 = 1'b1;
         prev0 = {m0.out, m0.busy, m0.done};
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL mon0 unexpected change edge=%0d out=%b busy=%b done=%b",
                     edge_n, m0.out, m0.busy, m0.done);
         end else begin
            ev0 = q0.pop_front();
            if (ev0.e != edge_n || ev0.o != m0.out || ev0.b != m0.busy || ev0.d != m0.done) begin
               errors++;
               $display("FAIL mon0 got edge=%0d out=%b busy=%b done=%b want edge=%0d out=%b busy=%b done=%b",
                        edge_n, m0.out, m0.busy, m0.done, ev0.e, ev0.o, ev0.b, ev0.d);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!seen1 || {m1.out, m1.busy, m1.done} != prev1) begin
         seen1 = 1'b1;
         prev1 = {m1.out, m1.busy, m1.done};
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL mon1 unexpected change edge=%0d out=%b busy=%b done=%b",
                     edge_n, m1.out, m1.busy, m1.done);
         end else begin
            ev1 = q1.pop_front();
            if (ev1.e != edge_n || ev1.o != m1.out || ev1.b != m1.busy || ev1.d != m1.done) begin
               errors++;
               $display("FAIL mon1 got edge=%0d out=%b busy=%b done=%b want edge=%0d out=%b busy=%b done=%b",
                        edge_n, m1.out, m1.busy, m1.done, ev1.e, ev1.o, ev1.b, ev1.d);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input bit s, input int e, input logic [2:0] o, input logic b, input logic d);
      ev_t x;
      x.e = e; x.o = o; x.b = b; x.d = d;
      if (s) q1.push_back(x);
      else   q0.push_back(x);
   endtask

   task automatic set_cfg(input bit s, input int ch, input int val, input int dly, input bit we);
      if (!s) begin
         m0.cfg_we  = we;
         m0.cfg_ch  = 2'(ch);
         m0.cfg_val = 1'(val);
         m0.cfg_dly = 4'(dly);
      end else begin
         m1.cfg_we  = we;
         m1.cfg_ch  = 2'(ch);
         m1.cfg_val = 1'(val);
         m1.cfg_dly = 8'(dly);
      end
   endtask

   task automatic do_cfg(input bit s, input int ch, input int val, input int dly);
      set_cfg(s, ch, val, dly, 1'b1);
      tick(1);
      set_cfg(s, 0, 0, 0, 1'b0);
   endtask

   task automatic go(input bit s, input bit md);
      if (!s) begin m0.mode = md; m0.start = 1'b1; end
      else    begin m1.mode = md; m1.start = 1'b1; end
      tick(1);
      m0.start = 1'b0;
      m1.start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   int t0;

   initial begin
      rst = 1'b1;
      set_cfg(0, 0, 0, 0, 1'b0);
      set_cfg(1, 0, 0, 0, 1'b0);
      m0.mode = 1'b0; m0.start = 1'b0; m0.abort = 1'b0;
      m1.mode = 1'b0; m1.start = 1'b0; m1.abort = 1'b0;
      push(0, 1, 3'b000, 1'b0, 1'b0);
      push(1, 1, 3'b000, 1'b0, 1'b0);
      tick(2);
      rst = 1'b0;

      // Sequential run 5/3/6; cfg with start, and start/cfg/mode mid-run, are ignored.
      do_cfg(0, 0, 1, 5);
      do_cfg(0, 1, 1, 3);
      do_cfg(0, 2, 1, 6);
      t0 = edge_n + 1;
      push(0, t0,      3'b000, 1'b1, 1'b0);
      push(0, t0 + 6,  3'b001, 1'b1, 1'b0);
      push(0, t0 + 10, 3'b011, 1'b1, 1'b0);
      push(0, t0 + 17, 3'b111, 1'b0, 1'b1);
      push(0, t0 + 18, 3'b111, 1'b0, 1'b0);
      set_cfg(0, 0, 0, 0, 1'b1);
      go(0, 1'b0);
      set_cfg(0, 0, 0, 0, 1'b0);
      tick(1);
      set_cfg(0, 1, 0, 0, 1'b1);
      m0.mode = 1'b1; m0.start = 1'b1;
      tick(1);
      set_cfg(0, 0, 0, 0, 1'b0);
      m0.start = 1'b0;
      tick(18);

      // Concurrent run, same delays, values 0 so each fall is visible.
      do_cfg(0, 0, 0, 5);
      do_cfg(0, 1, 0, 3);
      do_cfg(0, 2, 0, 6);
      t0 = edge_n + 1;
      push(0, t0,     3'b111, 1'b1, 1'b0);
      push(0, t0 + 4, 3'b101, 1'b1, 1'b0);
      push(0, t0 + 6, 3'b100, 1'b1, 1'b0);
      push(0, t0 + 7, 3'b000, 1'b0, 1'b1);
      push(0, t0 + 8, 3'b000, 1'b0, 1'b0);
      go(0, 1'b1);
      tick(10);

      // Equal delays update on the same edge.
      do_cfg(0, 0, 1, 2);
      do_cfg(0, 1, 1, 2);
      do_cfg(0, 2, 1, 2);
      t0 = edge_n + 1;
      push(0, t0,     3'b000, 1'b1, 1'b0);
      push(0, t0 + 3, 3'b111, 1'b0, 1'b1);
      push(0, t0 + 4, 3'b111, 1'b0, 1'b0);
      go(0, 1'b1);
      tick(6);

      // Abort at t0+12 during a sequential run.
      push(0, edge_n + 1, 3'b000, 1'b0, 1'b0);
      do_reset();
      do_cfg(0, 3, 0, 0);
      do_cfg(0, 0, 1, 5);
      do_cfg(0, 1, 1, 3);
      do_cfg(0, 2, 1, 6);
      t0 = edge_n + 1;
      push(0, t0,      3'b000, 1'b1, 1'b0);
      push(0, t0 + 6,  3'b001, 1'b1, 1'b0);
      push(0, t0 + 10, 3'b011, 1'b1, 1'b0);
      push(0, t0 + 12, 3'b011, 1'b0, 1'b0);
      go(0, 1'b0);
      tick(11);
      m0.abort = 1'b1;
      tick(1);
      m0.abort = 1'b0;
      tick(8);

      // Config accepted after abort: ch0 -> val 0 dly 0, concurrent run.
      do_cfg(0, 0, 0, 0);
      t0 = edge_n + 1;
      push(0, t0,     3'b011, 1'b1, 1'b0);
      push(0, t0 + 1, 3'b010, 1'b1, 1'b0);
      push(0, t0 + 7, 3'b110, 1'b0, 1'b1);
      push(0, t0 + 8, 3'b110, 1'b0, 1'b0);
      go(0, 1'b1);
      tick(10);

      // Reset at t0+8 mid-run, then runs with cleared registers.
      push(0, edge_n + 1, 3'b000, 1'b0, 1'b0);
      do_reset();
      do_cfg(0, 0, 1, 5);
      do_cfg(0, 1, 1, 3);
      do_cfg(0, 2, 1, 6);
      t0 = edge_n + 1;
      push(0, t0,     3'b000, 1'b1, 1'b0);
      push(0, t0 + 6, 3'b001, 1'b1, 1'b0);
      push(0, t0 + 8, 3'b000, 1'b0, 1'b0);
      go(0, 1'b0);
      tick(7);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(3);

      t0 = edge_n + 1;
      push(0, t0,     3'b000, 1'b1, 1'b0);
      push(0, t0 + 3, 3'b000, 1'b0, 1'b1);
      push(0, t0 + 4, 3'b000, 1'b0, 1'b0);
      go(0, 1'b0);
      tick(6);

      t0 = edge_n + 1;
      push(0, t0,     3'b000, 1'b1, 1'b0);
      push(0, t0 + 1, 3'b000, 1'b0, 1'b1);
      push(0, t0 + 2, 3'b000, 1'b0, 1'b0);
      go(0, 1'b1);
      tick(4);

      // DW=8: delay 255 concurrent, out-of-range channel write ignored.
      do_cfg(1, 3, 1, 0);
      do_cfg(1, 1, 1, 255);
      t0 = edge_n + 1;
      push(1, t0,       3'b000, 1'b1, 1'b0);
      push(1, t0 + 256, 3'b010, 1'b0, 1'b1);
      push(1, t0 + 257, 3'b010, 1'b0, 1'b0);
      go(1, 1'b1);
      tick(262);

      checks++;
      if (q0.size() != 0) begin
         errors++;
         $display("FAIL q0_drain pending=%0d want 0", q0.size());
      end
      checks++;
      if (q1.size() != 0) begin
         errors++;
         $display("FAIL q1_drain pending=%0d want 0", q1.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
